// File: rtl/arbitro_mem_original_pkg.sv
// Shared definitions for the original-image RAM arbiter.
//   tag_t    : owner of a read in flight (none, VGA display, resize).
//   wstate_t : HPS write sequencer states.
//   *_DEF    : default memory geometry and read latency.
package pkg_mem_original;

   typedef enum logic [1:0] {
      TAG_NONE  = 2'd0,
      TAG_VGA   = 2'd1,
      TAG_REDIM = 2'd2
   } tag_t;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_ESCREVE = 2'd1,
      W_DONE    = 2'd2
   } wstate_t;

   localparam int ADDR_W_DEF  = 15;
   localparam int DATA_W_DEF  = 8;
   localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/arbitro_mem_original_linha_atraso_leitura.sv
// Read-tag delay line. Each cycle a tag enters; it leaves DEPTH cycles
// later, lined up with the memory data of the read it describes.
//   clk     : clock
//   rst_n   : asynchronous active-low clear (all stages become TAG_NONE)
//   tag_in  : tag of the read issued this cycle
//   tag_out : tag of the read whose data is on the memory output now
module linha_atraso_leitura
   import pkg_mem_original::*;
#(
   parameter int DEPTH = MEM_LAT_DEF + 1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] tag_in,
   output logic [1:0] tag_out
);

   logic [1:0] pipe [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= TAG_NONE;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/arbitro_mem_original.sv
// Arbiter/sequencer for the original-image RAM (simple dual port).
// The read port is time-sliced: slot 0 of every VGA_PERIOD always reads
// the display address, the other slots serve resize read requests.
// HPS pixel writes go through a request/done four-phase handshake and
// are held off while a resize is running.
// Ports:
//   clk_100, reset          : clock, asynchronous active-low reset
//   hps_req/addr/data/done  : HPS write handshake; hps_busy = blocked/active
//   redim_ativo             : resize in progress (blocks new writes)
//   redim_req/addr/gnt      : resize read request, combinational grant
//   redim_valid/pixel       : resize read return (one-cycle pulse)
//   vga_addr/valid/pixel    : display read address and returned pixel
//   mem_*                   : memory instance ports (all registered out)
module arbitro_mem_original
   import pkg_mem_original::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_LAT    = MEM_LAT_DEF,
   parameter int VGA_PERIOD = 4
)(
   input  logic              clk_100,
   input  logic              reset,
   input  logic              hps_req,
   input  logic [ADDR_W-1:0] hps_addr,
   input  logic [DATA_W-1:0] hps_data,
   output logic              hps_done,
   output logic              hps_busy,
   input  logic              redim_ativo,
   input  logic              redim_req,
   input  logic [ADDR_W-1:0] redim_addr,
   output logic              redim_gnt,
   output logic              redim_valid,
   output logic [DATA_W-1:0] redim_pixel,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_valid,
   output logic [DATA_W-1:0] vga_pixel,
   output logic [ADDR_W-1:0] mem_rdaddress,
   output logic [ADDR_W-1:0] mem_wraddress,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   localparam int FW = $clog2(VGA_PERIOD);

   logic [FW-1:0]     fase;
   wstate_t           estado, estado_prox;
   logic              captura;
   logic [ADDR_W-1:0] addr_lat;
   logic [DATA_W-1:0] data_lat;
   tag_t              tag_in;
   logic [1:0]        tag_out;

   // Handshakes: redim_req/redim_addr are held by the requester until
   // redim_gnt is seen high in the same cycle; the read is then accepted.
   // hps_req is held until hps_done; hps_done stays high until hps_req is
   // seen low, after which a new request may be taken the next cycle.
   // A resize read is not granted while the write is being issued, so a
   // read of the same address never races the write on the memory.
   assign redim_gnt = (fase != '0) && redim_req && (estado != W_ESCREVE);

   always_comb begin
      tag_in = TAG_NONE;
      if (fase == '0)     tag_in = TAG_VGA;
      else if (redim_gnt) tag_in = TAG_REDIM;
   end

   // Slot counter and read address; VGA_PERIOD is a power of two so the
   // counter wraps on its own.
   always_ff @(posedge clk_100 or negedge reset) begin
      if (!reset) begin
         fase          <= '0;
         mem_rdaddress <= '0;
      end else begin
         fase <= fase + 1'b1;
         if (fase == '0)     mem_rdaddress <= vga_addr;
         else if (redim_gnt) mem_rdaddress <= redim_addr;
      end
   end

   linha_atraso_leitura #(.DEPTH(MEM_LAT + 1)) u_linha (
      .clk     (clk_100),
      .rst_n   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Route the retiring memory word to its owner.
   always_ff @(posedge clk_100 or negedge reset) begin
      if (!reset) begin
         vga_valid   <= 1'b0;
         vga_pixel   <= '0;
         redim_valid <= 1'b0;
         redim_pixel <= '0;
      end else begin
         vga_valid   <= 1'b0;
         redim_valid <= 1'b0;
         case (tag_out)
            TAG_VGA: begin
               vga_pixel <= mem_q;
               vga_valid <= 1'b1;
            end
            TAG_REDIM: begin
               redim_pixel <= mem_q;
               redim_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Write sequencer: next state.
   always_comb begin
      estado_prox = estado;
      captura     = 1'b0;
      case (estado)
         W_IDLE: begin
            if (hps_req && !redim_ativo) begin
               estado_prox = W_ESCREVE;
               captura     = 1'b1;
            end
         end
         W_ESCREVE: estado_prox = W_DONE;
         W_DONE:    if (!hps_req) estado_prox = W_IDLE;
         default:   estado_prox = W_IDLE;
      endcase
   end

   // Write sequencer: state, latched request, registered memory write.
   always_ff @(posedge clk_100 or negedge reset) begin
      if (!reset) begin
         estado        <= W_IDLE;
         addr_lat      <= '0;
         data_lat      <= '0;
         mem_wren      <= 1'b0;
         mem_wraddress <= '0;
         mem_data      <= '0;
      end else begin
         estado   <= estado_prox;
         mem_wren <= (estado == W_ESCREVE);
         if (captura) begin
            addr_lat <= hps_addr;
            data_lat <= hps_data;
         end
         if (estado == W_ESCREVE) begin
            mem_wraddress <= addr_lat;
            mem_data      <= data_lat;
         end
      end
   end

   assign hps_done = (estado == W_DONE);
   assign hps_busy = redim_ativo || (estado != W_IDLE);

endmodule

// File: tb/tb_arbitro_mem_original.sv
module tb_arbitro_mem_original;

   localparam int AW     = 15;
   localparam int DW     = 8;
   localparam int LAT    = 2;
   localparam int PER    = 4;
   localparam int NWORDS = 160 * 120;

   logic          clk_100, reset;
   logic          hps_req, hps_done, hps_busy, redim_ativo;
   logic [AW-1:0] hps_addr, redim_addr, vga_addr;
   logic [DW-1:0] hps_data, redim_pixel, vga_pixel;
   logic          redim_req, redim_gnt, redim_valid, vga_valid;
   logic [AW-1:0] mem_rdaddress, mem_wraddress;
   logic [DW-1:0] mem_data, mem_q;
   logic          mem_wren;

   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   initial clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   arbitro_mem_original #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .VGA_PERIOD(PER)
   ) dut (
      .clk_100(clk_100), .reset(reset),
      .hps_req(hps_req), .hps_addr(hps_addr), .hps_data(hps_data),
      .hps_done(hps_done), .hps_busy(hps_busy), .redim_ativo(redim_ativo),
      .redim_req(redim_req), .redim_addr(redim_addr), .redim_gnt(redim_gnt),
      .redim_valid(redim_valid), .redim_pixel(redim_pixel),
      .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_pixel(vga_pixel),
      .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress),
      .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // External RAM: two-cycle read latency, old data on read/write collision.
   logic [DW-1:0] ram       [0:32767];
   logic [DW-1:0] model_mem [0:32767];
   logic [DW-1:0] q1;
   initial begin
      q1    = '0;
      mem_q = '0;
   end
   always @(posedge clk_100) begin
      q1    <= ram[mem_rdaddress];
      mem_q <= q1;
      if (mem_wren) ram[mem_wraddress] <= mem_data;
   end

   // Cycles since reset release; slot 0 is every PER-th cycle from 0.
   int cyc;
   always @(posedge clk_100 or negedge reset)
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_vga_q[$];
   int            exp_vga_t[$];
   logic [DW-1:0] exp_redim_q[$];
   int            exp_redim_t[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d got=event want=none", name, cyc);
   endtask

   // Write model: a request accepted in cycle a writes in a+2 and is
   // acknowledged from a+2 until the cycle the request is seen low.
   bit            w_active;
   int            w_acc;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;

   always @(negedge clk_100) begin
      bit exp_wren, exp_done, exp_esc, exp_gnt;
      logic [DW-1:0] p;
      int t;
      if (!reset) begin
         chk("reset_outputs",
             {hps_done, hps_busy, redim_gnt, redim_valid, redim_pixel, vga_valid,
              vga_pixel, mem_rdaddress, mem_wraddress, mem_data, mem_wren}, 64'd0);
         exp_vga_q.delete();   exp_vga_t.delete();
         exp_redim_q.delete(); exp_redim_t.delete();
         w_active = 1'b0;
      end else begin
         exp_esc  = w_active && (cyc == w_acc + 1);
         exp_wren = w_active && (cyc == w_acc + 2);
         exp_done = w_active && (cyc >= w_acc + 2);
         chk("mem_wren", mem_wren, exp_wren);
         if (exp_wren) begin
            chk("mem_wraddress", mem_wraddress, w_addr);
            chk("mem_data", mem_data, w_data);
            model_mem[w_addr] = w_data;
         end
         chk("hps_done", hps_done, exp_done);
         chk("hps_busy", hps_busy, w_active || redim_ativo);

         exp_gnt = redim_req && (cyc % PER != 0) && !exp_esc;
         chk("redim_gnt", redim_gnt, exp_gnt);
         if (cyc % PER == 0) begin
            exp_vga_q.push_back(model_mem[vga_addr]);
            exp_vga_t.push_back(cyc + 2 + LAT);
         end
         if (exp_gnt) begin
            exp_redim_q.push_back(model_mem[redim_addr]);
            exp_redim_t.push_back(cyc + 2 + LAT);
         end

         if (vga_valid || (exp_vga_t.size() > 0 && exp_vga_t[0] == cyc)) begin
            if (exp_vga_t.size() == 0) fail_now("vga_spurious");
            else begin
               p = exp_vga_q.pop_front();
               t = exp_vga_t.pop_front();
               chk("vga_valid", vga_valid, 1);
               chk("vga_time", cyc, t);
               chk("vga_pixel", vga_pixel, p);
            end
         end
         if (redim_valid || (exp_redim_t.size() > 0 && exp_redim_t[0] == cyc)) begin
            if (exp_redim_t.size() == 0) fail_now("redim_spurious");
            else begin
               p = exp_redim_q.pop_front();
               t = exp_redim_t.pop_front();
               chk("redim_valid", redim_valid, 1);
               chk("redim_time", cyc, t);
               chk("redim_pixel", redim_pixel, p);
            end
         end

         if (w_active && exp_done && !hps_req) w_active = 1'b0;
         else if (!w_active && hps_req && !redim_ativo) begin
            w_active = 1'b1;
            w_acc    = cyc;
            w_addr   = hps_addr;
            w_data   = hps_data;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   task automatic hps_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
      int n = 0;
      hps_addr = a;
      hps_data = d;
      hps_req  = 1'b1;
      while (!hps_done && n < 100) begin tick(); n++; end
      if (!hps_done) fail_now("hps_done_timeout");
      repeat (hold) tick();
      hps_req = 1'b0;
      n = 0;
      while (hps_done && n < 10) begin tick(); n++; end
      if (hps_done) fail_now("hps_done_stuck");
   endtask

   task automatic redim_read(input logic [AW-1:0] a);
      bit g;
      int n = 0;
      redim_addr = a;
      redim_req  = 1'b1;
      do begin
         @(negedge clk_100);
         g = redim_gnt;
         tick();
         n++;
      end while (!g && n < 50);
      redim_req = 1'b0;
      if (!g) fail_now("redim_gnt_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int grants;
      bit g, d;
      logic [DW-1:0] v;
      reset = 1'b1;
      hps_req = 0; hps_addr = '0; hps_data = '0; redim_ativo = 0;
      redim_req = 0; redim_addr = '0; vga_addr = '0;
      for (int i = 0; i < 32768; i++) begin
         v = DW'($urandom);
         ram[i] = v;
         model_mem[i] = v;
      end
      for (int i = 0; i < 12; i++) begin
         ram[i] = DW'(8'h10 + i);
         model_mem[i] = DW'(8'h10 + i);
      end
      #1 reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;

      // Display-only traffic from address 0.
      repeat (20) tick();

      // Continuous resize stream over addresses 0..11.
      redim_addr = '0;
      redim_req  = 1'b1;
      grants     = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_100);
         g = redim_gnt;
         tick();
         if (g) begin
            grants++;
            redim_addr = redim_addr + 1'b1;
         end
      end
      redim_req = 1'b0;
      chk("grants_in_16", grants, 12);
      repeat (8) tick();

      // HPS write followed by a resize read of the same pixel.
      hps_write(15'h12C0, 8'hA5, 3);
      redim_read(15'h12C0);
      repeat (8) tick();

      // Write held off by an active resize, released afterwards.
      redim_ativo = 1'b1;
      hps_addr    = 15'h0100;
      hps_data    = 8'h3C;
      hps_req     = 1'b1;
      repeat (50) tick();
      redim_ativo = 1'b0;
      hps_write(15'h0100, 8'h3C, 1);
      redim_read(15'h0100);

      // Resize request arriving together with a write.
      hps_addr   = 15'h0200;
      hps_data   = 8'h77;
      hps_req    = 1'b1;
      redim_addr = 15'h0200;
      redim_req  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_100);
         g = redim_gnt;
         tick();
         if (g) redim_addr = AW'($urandom_range(0, NWORDS - 1));
      end
      redim_req = 1'b0;
      hps_req   = 1'b0;
      repeat (6) tick();

      // Reset with reads in flight.
      redim_addr = 15'h0005;
      redim_req  = 1'b1;
      repeat (3) tick();
      redim_req = 1'b0;
      reset     = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (12) tick();

      // Randomized mixed traffic.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_100);
         g = redim_gnt;
         d = hps_done;
         tick();
         if ($urandom_range(0, 15) == 0) vga_addr = AW'($urandom_range(0, NWORDS - 1));
         if (!redim_req) begin
            if ($urandom_range(0, 1) == 1) begin
               redim_req  = 1'b1;
               redim_addr = AW'($urandom_range(0, NWORDS - 1));
            end
         end else if (g) begin
            redim_req  = 1'($urandom_range(0, 1));
            redim_addr = AW'($urandom_range(0, NWORDS - 1));
         end
         if (!hps_req) begin
            if ($urandom_range(0, 7) == 0) begin
               hps_req  = 1'b1;
               hps_addr = AW'($urandom_range(0, NWORDS - 1));
               hps_data = DW'($urandom);
            end
         end else if (d && $urandom_range(0, 1) == 1) hps_req = 1'b0;
         if ($urandom_range(0, 31) == 0) redim_ativo = ~redim_ativo;
      end
      redim_req   = 1'b0;
      redim_ativo = 1'b0;
      hps_req     = 1'b0;
      repeat (12) tick();
      @(negedge clk_100);
      #1;
      chk("redim_q_drained", exp_redim_t.size(), 0);
      chk("vga_q_pending", exp_vga_t.size() <= 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
